// File: rtl/sd_pkg.sv
// Shared SD data-path types and helpers used by the DAT receiver and transmitter benches.
package sd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StDat,
    StCrc,
    StEndBit
  } dat_rx_state_e;

  localparam int unsigned CrcBits   = 16;
  localparam logic [15:0] Crc16Poly = 16'h1021;

  // Nibble k of a word: even k is the high nibble of byte k/2, odd k the low nibble.
  function automatic logic [31:0] place_nibble(input logic [31:0] word,
                                               input logic [2:0]  k,
                                               input logic [3:0]  nib);
    logic [31:0] res;
    logic [4:0]  base;
    res  = word;
    base = {k[2:1], ~k[0], 2'b00};
    res[base +: 4] = nib;
    return res;
  endfunction

endpackage

// File: rtl/dat_read_if.sv
// DAT receive bus between the command/host side (master) and the dat_read block (slave).
interface dat_read_if;
  logic        start_i;
  logic        stop_i;
  logic [3:0]  dat_i;
  logic [31:0] dat_o;
  logic        dat_valid_o;
  logic        done_o;
  logic [3:0]  crc_err_o;
  logic        end_bit_err_o;
  logic        timeout_o;
  logic        busy_o;

  modport master (
    output start_i, stop_i, dat_i,
    input  dat_o, dat_valid_o, done_o, crc_err_o, end_bit_err_o, timeout_o, busy_o
  );

  modport slave (
    input  start_i, stop_i, dat_i,
    output dat_o, dat_valid_o, done_o, crc_err_o, end_bit_err_o, timeout_o, busy_o
  );
endinterface

// File: rtl/counter.sv
// Generic up-counter with synchronous reset and clear.
module counter #(
  parameter int unsigned Width = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/crc16_read.sv
// Serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT line.
module crc16_read
  import sd_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic               dat_ser_i,
  output logic [CrcBits-1:0] crc_o
);

  logic [CrcBits-1:0] crc_q, crc_d;
  logic               fb;

  always_comb begin
    fb    = dat_ser_i ^ crc_q[CrcBits-1];
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[CrcBits-2:0], 1'b0} ^ (fb ? Crc16Poly : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/dat_read.sv
// SD 4-bit DAT block receiver: start bit, NumWords words, per-line CRC16, end bit.
// Optional start-bit timeout enabled by defining DAT_READ_TIMEOUT_EN.
module dat_read
  import sd_pkg::*;
#(
  parameter int unsigned NumWords      = 128,
  parameter int unsigned TimeoutCycles = 65536
) (
  input logic       sd_clk_i,
  input logic       rst_i,
  dat_read_if.slave bus
);

  localparam int unsigned   CntW    = 11;
  localparam logic [CntW-1:0] LastNib = CntW'(NumWords * 8 - 1);
  localparam logic [CntW-1:0] LastCrc = CntW'(CrcBits - 1);

  if (NumWords < 1 || NumWords > 256) begin : gen_bad_numwords
    $error("dat_read: NumWords must fit the 11-bit nibble counter");
  end
  if (TimeoutCycles < 2 || TimeoutCycles > 65536) begin : gen_bad_timeout
    $error("dat_read: TimeoutCycles must fit the 16-bit wait counter");
  end

  dat_rx_state_e   state_q;
  logic [CntW-1:0] cnt;
  logic            cnt_clr, cnt_en;
  logic            crc_clr, crc_en;
  logic [3:0][CrcBits-1:0] crc_calc;
  logic [3:0]      crc_bit;
  logic            start_ok, nibble_last, crc_last;

  logic [31:0] word_q, dat_q;
  logic        dat_valid_q, done_q, end_bit_err_q, timeout_q;
  logic [3:0]  crc_err_q;

`ifdef DAT_READ_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);
  logic [15:0] wait_cnt_q;
`endif

  assign start_ok    = bus.start_i && !bus.stop_i;
  assign nibble_last = (cnt == LastNib);
  assign crc_last    = (cnt == LastCrc);

  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b1;
    case (state_q)
      StDat: begin
        cnt_en  = 1'b1;
        cnt_clr = nibble_last || bus.stop_i;
      end
      StCrc: begin
        cnt_en  = 1'b1;
        cnt_clr = crc_last || bus.stop_i;
      end
      default: ;
    endcase
  end

  assign crc_clr = (state_q == StIdle) && start_ok;
  assign crc_en  = (state_q == StDat) && !bus.stop_i;

  counter #(
    .Width(CntW)
  ) u_bit_cnt (
    .clk_i (sd_clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt)
  );

  for (genvar l = 0; l < 4; l++) begin : gen_crc
    crc16_read u_crc (
      .clk_i     (sd_clk_i),
      .rst_i     (rst_i),
      .clear_i   (crc_clr),
      .en_i      (crc_en),
      .dat_ser_i (bus.dat_i[l]),
      .crc_o     (crc_calc[l])
    );
    // Received CRC arrives MSB first; 15 - cnt is the bitwise inverse of cnt[3:0].
    assign crc_bit[l] = crc_calc[l][~cnt[3:0]];
  end

  always_ff @(posedge sd_clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      word_q        <= '0;
      dat_q         <= '0;
      dat_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      crc_err_q     <= '0;
      end_bit_err_q <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef DAT_READ_TIMEOUT_EN
      wait_cnt_q    <= '0;
`endif
    end else begin
      dat_valid_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      if (state_q != StIdle && bus.stop_i) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_ok) begin
              state_q       <= StWaitStart;
              crc_err_q     <= '0;
              end_bit_err_q <= 1'b0;
`ifdef DAT_READ_TIMEOUT_EN
              wait_cnt_q    <= '0;
`endif
            end
          end
          StWaitStart: begin
            if (bus.dat_i == 4'h0) begin
              state_q <= StDat;
            end
`ifdef DAT_READ_TIMEOUT_EN
            else if (wait_cnt_q == TimeoutLast) begin
              state_q   <= StIdle;
              timeout_q <= 1'b1;
            end
            wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
          end
          StDat: begin
            word_q <= place_nibble(word_q, cnt[2:0], bus.dat_i);
            if (cnt[2:0] == 3'd7) begin
              dat_q       <= place_nibble(word_q, cnt[2:0], bus.dat_i);
              dat_valid_q <= 1'b1;
            end
            if (nibble_last) begin
              state_q <= StCrc;
            end
          end
          StCrc: begin
            crc_err_q <= crc_err_q | (bus.dat_i ^ crc_bit);
            if (crc_last) begin
              state_q <= StEndBit;
            end
          end
          StEndBit: begin
            end_bit_err_q <= (bus.dat_i != 4'hF);
            done_q        <= 1'b1;
            state_q       <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.dat_o         = dat_q;
  assign bus.dat_valid_o   = dat_valid_q;
  assign bus.done_o        = done_q;
  assign bus.crc_err_o     = crc_err_q;
  assign bus.end_bit_err_o = end_bit_err_q;
  assign bus.timeout_o     = timeout_q;
  assign bus.busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_dat_read.sv
// Directed bench for dat_read: good block, CRC error, end-bit error, stop, timeout, reset.
module tb_dat_read;

  localparam int unsigned NumWords      = 128;
  localparam int unsigned TimeoutCycles = 64;
  localparam int          NumNibs       = NumWords * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dat_read_if bus ();

  dat_read #(
    .NumWords      (NumWords),
    .TimeoutCycles (TimeoutCycles)
  ) dut (
    .sd_clk_i (clk),
    .rst_i    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt     = 0;
  int dcnt     = 0;
  int tcnt     = 0;
  int blk_base = 0;
  logic [15:0] crc_ref [4];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int i);
    return 8'(i % 256);
  endfunction

  function automatic logic [3:0] nib_at(input int j);
    logic [7:0] b;
    b = byte_at(j / 2);
    return (j % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  function automatic logic [31:0] exp_word(input int w);
    return {byte_at(4 * w + 3), byte_at(4 * w + 2), byte_at(4 * w + 1), byte_at(4 * w)};
  endfunction

  function automatic logic [15:0] crc_line(input int l);
    logic [15:0] c;
    logic [3:0]  n;
    logic        fb;
    c = 16'h0;
    for (int j = 0; j < NumNibs; j++) begin
      n  = nib_at(j);
      fb = n[l] ^ c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (bus.dat_valid_o) begin
      check_eq("word", bus.dat_o, exp_word(vcnt - blk_base));
      vcnt++;
    end
    if (bus.done_o) dcnt++;
    if (bus.timeout_o) tcnt++;
  end

  // abort_at < 0 runs a full block; otherwise stop (or reset) is applied at that nibble.
  task automatic run_block(input int flip_line, input int flip_bit, input logic [3:0] end_nib,
                           input int abort_at, input bit abort_rst, input bit full_chk);
    logic [3:0] nib;
    blk_base = vcnt;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.dat_i   = 4'hF;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.dat_i   = 4'h0;
    check_eq("busy_wait", 32'(bus.busy_o), 32'd1);
    for (int j = 0; j < NumNibs; j++) begin
      @(negedge clk);
      bus.dat_i = nib_at(j);
      if (j == abort_at) begin
        if (abort_rst) rst = 1'b1;
        else bus.stop_i = 1'b1;
        return;
      end
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0 && full_chk) check_eq("valid_at_crc0", 32'(bus.dat_valid_o), 32'd1);
      for (int l = 0; l < 4; l++) begin
        nib[l] = crc_ref[l][15 - i];
        if (l == flip_line && (15 - i) == flip_bit) nib[l] = ~nib[l];
      end
      bus.dat_i = nib;
    end
    @(negedge clk);
    bus.dat_i = end_nib;
    @(negedge clk);
    bus.dat_i = 4'hF;
    check_eq("done_pulse", 32'(bus.done_o), 32'd1);
    @(negedge clk);
    check_eq("done_single", 32'(bus.done_o), 32'd0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.dat_i   = 4'hF;
    for (int l = 0; l < 4; l++) crc_ref[l] = crc_line(l);
    repeat (3) @(negedge clk);
    check_eq("rst_dat_o", bus.dat_o, 32'h0);
    check_eq("rst_valid", 32'(bus.dat_valid_o), 32'd0);
    check_eq("rst_done", 32'(bus.done_o), 32'd0);
    check_eq("rst_crc_err", 32'(bus.crc_err_o), 32'd0);
    check_eq("rst_end_err", 32'(bus.end_bit_err_o), 32'd0);
    check_eq("rst_timeout", 32'(bus.timeout_o), 32'd0);
    check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b0;

    // Stop wins over start in IDLE.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.stop_i  = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    check_eq("start_stop_idle", 32'(bus.busy_o), 32'd0);

    // 1: clean block.
    run_block(-1, 0, 4'hF, -1, 1'b0, 1'b1);
    check_eq("t1_words", 32'(vcnt - blk_base), 32'd128);
    check_eq("t1_crc_err", 32'(bus.crc_err_o), 32'h0);
    check_eq("t1_end_err", 32'(bus.end_bit_err_o), 32'd0);
    check_eq("t1_dones", 32'(dcnt), 32'd1);
    check_eq("t1_last_word", bus.dat_o, 32'hFFFEFDFC);
    check_eq("t1_idle", 32'(bus.busy_o), 32'd0);

    // 2: DAT2 CRC bit 5 corrupted.
    run_block(2, 5, 4'hF, -1, 1'b0, 1'b0);
    check_eq("t2_words", 32'(vcnt - blk_base), 32'd128);
    check_eq("t2_crc_err", 32'(bus.crc_err_o), 32'h4);
    check_eq("t2_end_err", 32'(bus.end_bit_err_o), 32'd0);
    check_eq("t2_dones", 32'(dcnt), 32'd2);

    // 3: bad end bit; CRC flags from block 2 must have been cleared.
    run_block(-1, 0, 4'hE, -1, 1'b0, 1'b0);
    check_eq("t3_end_err", 32'(bus.end_bit_err_o), 32'd1);
    check_eq("t3_crc_err", 32'(bus.crc_err_o), 32'h0);
    check_eq("t3_dones", 32'(dcnt), 32'd3);

    // 4: stop at nibble 100.
    run_block(-1, 0, 4'hF, 100, 1'b0, 1'b0);
    @(negedge clk);
    bus.stop_i = 1'b0;
    check_eq("t4_busy", 32'(bus.busy_o), 32'd0);
    repeat (20) @(negedge clk);
    check_eq("t4_words", 32'(vcnt - blk_base), 32'd12);
    check_eq("t4_dones", 32'(dcnt), 32'd3);

    // 5: no start bit.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.dat_i   = 4'hF;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (63) @(negedge clk);
    check_eq("t5_busy_before", 32'(bus.busy_o), 32'd1);
    check_eq("t5_no_early_to", 32'(tcnt), 32'd0);
    @(negedge clk);
`ifdef DAT_READ_TIMEOUT_EN
    check_eq("t5_timeout", 32'(bus.timeout_o), 32'd1);
    check_eq("t5_busy_after", 32'(bus.busy_o), 32'd0);
`else
    check_eq("t5_timeout", 32'(bus.timeout_o), 32'd0);
    check_eq("t5_busy_after", 32'(bus.busy_o), 32'd1);
    repeat (10) @(negedge clk);
    check_eq("t5_still_busy", 32'(bus.busy_o), 32'd1);
    bus.stop_i = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
    check_eq("t5_stop_idle", 32'(bus.busy_o), 32'd0);
`endif
    check_eq("t5_dones", 32'(dcnt), 32'd3);

    // 6: reset mid-block, then a clean block.
    run_block(-1, 0, 4'hF, 500, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("t6_dat_o", bus.dat_o, 32'h0);
    check_eq("t6_valid", 32'(bus.dat_valid_o), 32'd0);
    check_eq("t6_busy", 32'(bus.busy_o), 32'd0);
    check_eq("t6_done", 32'(bus.done_o), 32'd0);
    check_eq("t6_words", 32'(vcnt - blk_base), 32'd62);
    rst = 1'b0;
    run_block(-1, 0, 4'hF, -1, 1'b0, 1'b1);
    check_eq("t6_words_after", 32'(vcnt - blk_base), 32'd128);
    check_eq("t6_crc_err", 32'(bus.crc_err_o), 32'h0);
    check_eq("t6_end_err", 32'(bus.end_bit_err_o), 32'd0);
    check_eq("t6_dones", 32'(dcnt), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
